// File: rtl/intt_pkg.sv
// Shared definitions for the INTT stage sequencer: default sizes, FSM state
// encoding and the words-per-stage helper.
package intt_pkg;

   localparam int INTT_LOG_N          = 12;
   localparam int INTT_ADDR_W         = 9;
   localparam int INTT_LOG_CORE_COUNT = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } intt_state_e;

   // Each core consumes two coefficients per butterfly and there are two
   // router address inputs, hence the extra factor of four.
   function automatic int words_per_stage(input int log_n, input int log_core_count);
      return 1 << (log_n - log_core_count - 2);
   endfunction

endpackage

// File: rtl/intt_stage_controller_if.sv
// Transform handshake plus memory/router control bundle of the stage
// sequencer. The host drives start/hold, the controller drives the rest.
interface intt_stage_controller_if #(
   parameter int ADDR_W = intt_pkg::INTT_ADDR_W
);
   logic                   start;
   logic                   hold;
   logic                   busy;
   logic                   done;
   logic [3:0]             log_m;
   logic [3:0]             log_t;
   logic                   rd_en;
   logic [1:0][ADDR_W-1:0] rd_address;
   logic                   wb_en;
   logic                   out_valid;

   modport master (
      output start, hold,
      input  busy, done, log_m, log_t, rd_en, rd_address, wb_en, out_valid
   );

   modport slave (
      input  start, hold,
      output busy, done, log_m, log_t, rd_en, rd_address, wb_en, out_valid
   );
endinterface

// File: rtl/intt_valid_delay.sv
// Fixed-latency shift register carrying {valid, last_stage} from the read
// issue point to the write-back point. It never stalls: words already in the
// pipeline always complete.
module intt_valid_delay #(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] last_q;
   logic [DEPTH-1:0] last_d;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tap
         if (gi == 0) begin : g_head
            assign valid_d[gi] = in_valid;
            assign last_d[gi]  = in_last;
         end else begin : g_body
            assign valid_d[gi] = valid_q[gi-1];
            assign last_d[gi]  = last_q[gi-1];
         end
      end
   endgenerate

   // Advance the delay line every cycle; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/intt_stage_controller.sv
// Sequences the INTT datapath through all LOG_N butterfly stages: issues the
// per-stage read burst, waits for the pipeline to drain, then moves to the
// next stage. Outputs are registered; the read presented in a cycle is
// decided at the edge that starts that cycle.
module intt_stage_controller
   import intt_pkg::*;
#(
   parameter int LOG_CORE_COUNT = INTT_LOG_CORE_COUNT,
   parameter int LOG_N          = INTT_LOG_N,
   parameter int PIPE_DEPTH     = 8,
   parameter int ADDR_W         = INTT_ADDR_W
) (
   input logic                    clk,
   input logic                    rst_n,
   intt_stage_controller_if.slave bus
);

   localparam int W      = words_per_stage(LOG_N, LOG_CORE_COUNT);
   localparam int LOW_W  = (W > 1) ? $clog2(W) : 1;
   // One extra bit so idx can reach W, meaning "every word of the stage issued".
   localparam int IDX_W  = LOW_W + 1;
   localparam int DCNT_W = $clog2(PIPE_DEPTH) + 1;
   localparam logic [3:0]        LOG_M_INIT = 4'(LOG_N);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(W);
   localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(PIPE_DEPTH - 1);

   intt_state_e       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              pp_q, pp_d;
   logic [3:0]        log_m_q, log_m_d;
   logic [3:0]        log_t_q, log_t_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wb_en_w;
   logic              out_valid_w;

   // Ping-pong bank bit on top, word index at the bottom, zeros in between.
   function automatic logic [ADDR_W-1:0] make_addr(input logic pp,
                                                   input logic [LOW_W-1:0] idx);
      logic [ADDR_W-1:0] a;
      a             = '0;
      a[LOW_W-1:0]  = idx;
      a[ADDR_W-1]   = pp;
      return a;
   endfunction

   // Next-state and next-output logic; hold freezes every sequencing register.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      dcnt_d    = dcnt_q;
      pp_d      = pp_q;
      log_m_d   = log_m_q;
      log_t_d   = log_t_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               busy_d  = 1'b1;
               log_m_d = LOG_M_INIT;
               log_t_d = 4'd0;
               pp_d    = 1'b0;
               dcnt_d  = '0;
               idx_d   = '0;
               if (!bus.hold) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = make_addr(1'b0, '0);
                  idx_d     = IDX_W'(1);
               end
            end
         end
         ISSUE: begin
            if (!bus.hold) begin
               if (idx_q == IDX_LAST) begin
                  state_d = DRAIN;
                  dcnt_d  = '0;
                  idx_d   = '0;
               end else begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = make_addr(pp_q, idx_q[LOW_W-1:0]);
                  idx_d     = idx_q + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!bus.hold) begin
               if (dcnt_q == DCNT_LAST) begin
                  dcnt_d = '0;
                  if (log_m_q == 4'd1) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     // Next stage starts reading in the same edge the drain ends.
                     state_d   = ISSUE;
                     log_m_d   = log_m_q - 4'd1;
                     log_t_d   = log_t_q + 4'd1;
                     pp_d      = ~pp_q;
                     rd_en_d   = 1'b1;
                     rd_addr_d = make_addr(~pp_q, '0);
                     idx_d     = IDX_W'(1);
                  end
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            log_m_d = LOG_M_INIT;
            log_t_d = 4'd0;
            pp_d    = 1'b0;
            idx_d   = '0;
            dcnt_d  = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register all sequencing state and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         dcnt_q    <= '0;
         pp_q      <= 1'b0;
         log_m_q   <= LOG_M_INIT;
         log_t_q   <= 4'd0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dcnt_q    <= dcnt_d;
         pp_q      <= pp_d;
         log_m_q   <= log_m_d;
         log_t_q   <= log_t_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // The last-stage tag is taken from the stage that issued the word, so the
   // tag itself is the registered router output valid.
   intt_valid_delay #(
      .DEPTH (PIPE_DEPTH)
   ) u_valid_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_en_q),
      .in_last   (rd_en_q & (log_m_q == 4'd1)),
      .out_valid (wb_en_w),
      .out_last  (out_valid_w)
   );

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.log_m         = log_m_q;
   assign bus.log_t         = log_t_q;
   assign bus.rd_en         = rd_en_q;
   assign bus.rd_address[0] = rd_addr_q;
   assign bus.rd_address[1] = rd_addr_q;
   assign bus.wb_en         = wb_en_w;
   assign bus.out_valid     = out_valid_w;

endmodule
